// File: rtl/spidergon_vc_allocator.sv
// ---------------------------------------------------------------------------
// spidergon_vc_allocator
//
// Virtual-channel allocator and credit tracker for one output port of a
// spidergon router node. The output port's downstream VC buffers are shared
// among the node's input ports (local, clockwise, anti-clockwise, across).
// A requesting head flit gets a free VC chosen by round-robin over the ports.
// The port keeps that VC until its tail flit passes. Flit forwarding is
// gated on per-VC downstream credits.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous reset, active-low
//   vc_req         [P]      port p has a head flit waiting for a VC
//   flit_sent      [P]      port p forwards one flit on its VC this cycle
//   flit_is_tail   [P]      qualifies flit_sent[p]: this flit ends the packet
//   credit_return  [V]      downstream freed one slot of VC v
//   vc_grant       [P]      one-cycle grant pulse to port p
//   vc_grant_id    [P*VW]   VC owned by port p (valid from grant to release)
//   vc_busy        [V]      VC v is allocated
//   vc_owner       [V*PW]   owning port of VC v (valid while vc_busy[v])
//   port_can_send  [P]      port p owns a VC that has credit left
//   credit_count   [V*CW]   current credit count of each VC
//   protocol_error          sticky protocol-violation flag
// ---------------------------------------------------------------------------
module spidergon_vc_allocator #(
   parameter int NUM_OF_INPUT_PORTS      = 4,
   parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
   parameter int VC_CREDITS              = 2,
   parameter int PORT_ID_WIDTH = (NUM_OF_INPUT_PORTS > 1) ? $clog2(NUM_OF_INPUT_PORTS) : 1,
   parameter int VC_ID_WIDTH   = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1
) (
   input  logic                                                    clk,
   input  logic                                                    reset,
   input  logic [NUM_OF_INPUT_PORTS-1:0]                           vc_req,
   input  logic [NUM_OF_INPUT_PORTS-1:0]                           flit_sent,
   input  logic [NUM_OF_INPUT_PORTS-1:0]                           flit_is_tail,
   input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0]                      credit_return,
   output logic [NUM_OF_INPUT_PORTS-1:0]                           vc_grant,
   output logic [NUM_OF_INPUT_PORTS*VC_ID_WIDTH-1:0]               vc_grant_id,
   output logic [NUM_OF_VIRTUAL_CHANNELS-1:0]                      vc_busy,
   output logic [NUM_OF_VIRTUAL_CHANNELS*PORT_ID_WIDTH-1:0]        vc_owner,
   output logic [NUM_OF_INPUT_PORTS-1:0]                           port_can_send,
   output logic [NUM_OF_VIRTUAL_CHANNELS*$clog2(VC_CREDITS+1)-1:0] credit_count,
   output logic                                                    protocol_error
);

   localparam int P  = NUM_OF_INPUT_PORTS;
   localparam int V  = NUM_OF_VIRTUAL_CHANNELS;
   localparam int PW = PORT_ID_WIDTH;
   localparam int VW = VC_ID_WIDTH;
   localparam int CW = $clog2(VC_CREDITS + 1);
   localparam logic [CW-1:0] CREDIT_MAX = CW'(VC_CREDITS);

   // Registered state
   logic [V-1:0]  vc_busy_reg;
   logic [PW-1:0] vc_owner_reg [V];
   logic [P-1:0]  port_owns_reg;
   logic [VW-1:0] port_vc_reg [P];
   logic [P-1:0]  vc_grant_reg;
   logic [CW-1:0] credit_reg [V];
   logic [PW-1:0] rr_ptr_reg;
   logic          protocol_error_reg;

   // Combinational
   logic [P-1:0]  can_send;
   logic [P-1:0]  send_ok;
   logic [P-1:0]  release_port;
   logic [V-1:0]  credit_dec;
   logic [V-1:0]  credit_ret_err;
   logic [CW-1:0] credit_next [V];
   logic [P-1:0]  eligible;
   logic          free_valid;
   logic [VW-1:0] free_vc;
   logic          pick_valid;
   logic [PW-1:0] pick_port;
   logic          grant_fire;
   logic [PW-1:0] rr_ptr_next;
   logic          protocol_error_next;

   // A port may forward only while it owns a VC whose credit is non-zero.
   // An illegal send is flagged and otherwise ignored: no credit change and,
   // for a tail, no release.
   genvar gi;
   generate
      for (gi = 0; gi < P; gi++) begin : g_port
         assign can_send[gi]     = port_owns_reg[gi] & (credit_reg[port_vc_reg[gi]] != '0);
         assign send_ok[gi]      = flit_sent[gi] & can_send[gi];
         assign release_port[gi] = send_ok[gi] & flit_is_tail[gi];
      end
   endgenerate

   // Each VC has at most one owner, so at most one port decrements a VC.
   always_comb begin
      credit_dec = '0;
      for (int p = 0; p < P; p++) begin
         if (send_ok[p]) begin
            credit_dec[port_vc_reg[p]] = 1'b1;
         end
      end
   end

   // A send and a return in the same cycle cancel. A return into a full
   // VC is a protocol error and saturates.
   always_comb begin
      for (int v = 0; v < V; v++) begin
         credit_next[v]    = credit_reg[v];
         credit_ret_err[v] = 1'b0;
         if (credit_dec[v] && !credit_return[v]) begin
            credit_next[v] = credit_reg[v] - 1'b1;
         end else if (!credit_dec[v] && credit_return[v]) begin
            if (credit_reg[v] == CREDIT_MAX) begin
               credit_ret_err[v] = 1'b1;
            end else begin
               credit_next[v] = credit_reg[v] + 1'b1;
            end
         end
      end
   end

   assign protocol_error_next = protocol_error_reg
                              | (|(flit_sent & ~can_send))
                              | (|credit_ret_err);

   // Allocation works only from registered state. A VC freed this cycle
   // therefore becomes grantable one cycle later.
   assign eligible = vc_req & ~port_owns_reg & ~vc_grant_reg;

   // Lowest-index free VC: scan downward so that the last hit wins.
   always_comb begin
      free_valid = 1'b0;
      free_vc    = '0;
      for (int v = V - 1; v >= 0; v--) begin
         if (!vc_busy_reg[v]) begin
            free_valid = 1'b1;
            free_vc    = VW'(v);
         end
      end
   end

   // First eligible port at or after the round-robin pointer, with wrap.
   // The scan runs from the farthest offset down so the nearest one wins.
   always_comb begin
      int idx;
      idx        = 0;
      pick_valid = 1'b0;
      pick_port  = '0;
      for (int i = P - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr_reg) + i) % P;
         if (eligible[idx]) begin
            pick_valid = 1'b1;
            pick_port  = PW'(idx);
         end
      end
   end

   assign grant_fire  = pick_valid & free_valid;
   assign rr_ptr_next = (int'(pick_port) == P - 1) ? '0 : pick_port + PW'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         vc_busy_reg        <= '0;
         port_owns_reg      <= '0;
         vc_grant_reg       <= '0;
         rr_ptr_reg         <= '0;
         protocol_error_reg <= 1'b0;
         for (int v = 0; v < V; v++) begin
            vc_owner_reg[v] <= '0;
            credit_reg[v]   <= CREDIT_MAX;
         end
         for (int p = 0; p < P; p++) begin
            port_vc_reg[p] <= '0;
         end
      end else begin
         vc_grant_reg       <= '0;
         protocol_error_reg <= protocol_error_next;
         for (int v = 0; v < V; v++) begin
            credit_reg[v] <= credit_next[v];
         end
         // A releasing port owns a busy VC, while a grant targets an idle
         // VC. The two updates therefore never touch the same VC.
         for (int p = 0; p < P; p++) begin
            if (release_port[p]) begin
               port_owns_reg[p]             <= 1'b0;
               vc_busy_reg[port_vc_reg[p]]  <= 1'b0;
            end
         end
         if (grant_fire) begin
            vc_grant_reg[pick_port]  <= 1'b1;
            port_owns_reg[pick_port] <= 1'b1;
            port_vc_reg[pick_port]   <= free_vc;
            vc_busy_reg[free_vc]     <= 1'b1;
            vc_owner_reg[free_vc]    <= pick_port;
            rr_ptr_reg               <= rr_ptr_next;
         end
      end
   end

   generate
      for (gi = 0; gi < P; gi++) begin : g_port_out
         assign vc_grant_id[gi*VW +: VW] = port_vc_reg[gi];
      end
      for (gi = 0; gi < V; gi++) begin : g_vc_out
         assign vc_owner[gi*PW +: PW]     = vc_owner_reg[gi];
         assign credit_count[gi*CW +: CW] = credit_reg[gi];
      end
   endgenerate

   assign vc_grant       = vc_grant_reg;
   assign vc_busy        = vc_busy_reg;
   assign port_can_send  = can_send;
   assign protocol_error = protocol_error_reg;

endmodule

// File: tb/tb_spidergon_vc_allocator.sv
module tb_spidergon_vc_allocator;

   localparam int P  = 4;
   localparam int V  = 2;
   localparam int C  = 2;
   localparam int PW = 2;
   localparam int VW = 1;
   localparam int CW = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [P-1:0]   vc_req, flit_sent, flit_is_tail;
   logic [V-1:0]   credit_return;
   logic [P-1:0]   vc_grant;
   logic [P*VW-1:0] vc_grant_id;
   logic [V-1:0]   vc_busy;
   logic [V*PW-1:0] vc_owner;
   logic [P-1:0]   port_can_send;
   logic [V*CW-1:0] credit_count;
   logic           protocol_error;

   spidergon_vc_allocator #(
      .NUM_OF_INPUT_PORTS(P), .NUM_OF_VIRTUAL_CHANNELS(V), .VC_CREDITS(C)
   ) dut (
      .clk(clk), .reset(reset), .vc_req(vc_req), .flit_sent(flit_sent),
      .flit_is_tail(flit_is_tail), .credit_return(credit_return),
      .vc_grant(vc_grant), .vc_grant_id(vc_grant_id), .vc_busy(vc_busy),
      .vc_owner(vc_owner), .port_can_send(port_can_send),
      .credit_count(credit_count), .protocol_error(protocol_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Ownership is a per-VC owner list (-1 = free); a port "owns" a VC if it
   // appears in that list. Credits are plain integers clamped to 0..C.
   int m_owner [V];
   int m_cred  [V];
   int m_gid   [P];
   bit m_grant [P];
   int m_rr;
   bit m_err;

   task automatic m_reset();
      for (int v = 0; v < V; v++) begin m_owner[v] = -1; m_cred[v] = C; end
      for (int p = 0; p < P; p++) begin m_gid[p] = 0; m_grant[p] = 0; end
      m_rr = 0; m_err = 0;
   endtask

   function automatic int m_vc_of(int p);
      for (int v = 0; v < V; v++) if (m_owner[v] == p) return v;
      return -1;
   endfunction

   function automatic bit m_can(int p);
      int v;
      v = m_vc_of(p);
      return (v >= 0) && (m_cred[v] > 0);
   endfunction

   task automatic model_step();
      bit can [P]; bit elig [P]; int vcp [P]; int dec [V]; int ret;
      int free, pick, nc;
      if (!reset) begin m_reset(); return; end
      for (int p = 0; p < P; p++) begin
         vcp[p]  = m_vc_of(p);
         can[p]  = m_can(p);
         elig[p] = vc_req[p] && (vcp[p] < 0) && !m_grant[p];
      end
      free = -1;
      for (int v = V - 1; v >= 0; v--) if (m_owner[v] < 0) free = v;
      pick = -1;
      for (int i = 0; i < P && pick < 0; i++) if (elig[(m_rr + i) % P]) pick = (m_rr + i) % P;
      for (int v = 0; v < V; v++) dec[v] = 0;
      for (int p = 0; p < P; p++) begin
         if (flit_sent[p]) begin
            if (!can[p]) m_err = 1;
            else dec[vcp[p]] = 1;
         end
      end
      for (int v = 0; v < V; v++) begin
         ret = credit_return[v] ? 1 : 0;
         if (ret == 1 && dec[v] == 0 && m_cred[v] == C) m_err = 1;
         nc = m_cred[v] - dec[v] + ret;
         m_cred[v] = (nc > C) ? C : nc;
      end
      for (int p = 0; p < P; p++)
         if (flit_sent[p] && can[p] && flit_is_tail[p]) m_owner[vcp[p]] = -1;
      for (int p = 0; p < P; p++) m_grant[p] = 0;
      if (pick >= 0 && free >= 0) begin
         m_owner[free] = pick; m_gid[pick] = free; m_grant[pick] = 1;
         m_rr = (pick + 1) % P;
      end
   endtask

   task automatic compare_model();
      logic [P-1:0] eg, ec; logic [V-1:0] eb; logic [V*CW-1:0] ecc;
      for (int p = 0; p < P; p++) begin eg[p] = m_grant[p]; ec[p] = m_can(p); end
      for (int v = 0; v < V; v++) begin
         eb[v] = (m_owner[v] >= 0);
         ecc[v*CW +: CW] = CW'(m_cred[v]);
      end
      chk("model_grant", 32'(vc_grant), 32'(eg));
      chk("model_busy", 32'(vc_busy), 32'(eb));
      chk("model_can_send", 32'(port_can_send), 32'(ec));
      chk("model_credits", 32'(credit_count), 32'(ecc));
      chk("model_error", 32'(protocol_error), 32'(m_err));
      for (int v = 0; v < V; v++)
         if (m_owner[v] >= 0) chk("model_owner", 32'(vc_owner[v*PW +: PW]), 32'(m_owner[v]));
      for (int p = 0; p < P; p++)
         if (m_vc_of(p) >= 0) chk("model_grant_id", 32'(vc_grant_id[p*VW +: VW]), 32'(m_gid[p]));
   endtask

   // Inputs are driven 1 time unit after an edge; outputs sampled likewise.
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      compare_model();
   endtask

   task automatic idle_inputs();
      vc_req = '0; flit_sent = '0; flit_is_tail = '0; credit_return = '0;
   endtask

   typedef struct {
      logic         rst;
      logic [P-1:0] req, sent, tail;
      logic [V-1:0] ret;
      logic [P-1:0] e_grant;
      logic [V-1:0] e_busy;
      logic [P-1:0] e_can;
      logic [V*CW-1:0] e_cc;
      logic         e_err;
   } vec_t;

   vec_t tbl [16];

   initial begin
      tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b1010, 1'b0};
      tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b1010, 1'b0};
      tbl[2]  = '{1'b1, 4'b0010, 4'b0000, 4'b0000, 2'b00, 4'b0010, 2'b01, 4'b0010, 4'b1010, 1'b0};
      tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b01, 4'b0010, 4'b1010, 1'b0};
      tbl[4]  = '{1'b1, 4'b0000, 4'b0010, 4'b0000, 2'b00, 4'b0000, 2'b01, 4'b0010, 4'b1001, 1'b0};
      tbl[5]  = '{1'b1, 4'b0000, 4'b0010, 4'b0000, 2'b00, 4'b0000, 2'b01, 4'b0000, 4'b1000, 1'b0};
      tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b01, 4'b0000, 2'b01, 4'b0010, 4'b1001, 1'b0};
      tbl[7]  = '{1'b1, 4'b0000, 4'b0010, 4'b0000, 2'b01, 4'b0000, 2'b01, 4'b0010, 4'b1001, 1'b0};
      tbl[8]  = '{1'b1, 4'b0000, 4'b0010, 4'b0010, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b1000, 1'b0};
      tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b01, 4'b0000, 2'b00, 4'b0000, 4'b1001, 1'b0};
      tbl[10] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b01, 4'b0000, 2'b00, 4'b0000, 4'b1010, 1'b0};
      tbl[11] = '{1'b1, 4'b0000, 4'b1000, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b1010, 1'b1};
      tbl[12] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b1010, 1'b1};
      tbl[13] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b1010, 1'b0};
      tbl[14] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b10, 4'b0000, 2'b00, 4'b0000, 4'b1010, 1'b1};
      tbl[15] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b1010, 1'b0};

      m_reset();
      reset = 1'b0;
      idle_inputs();
      #1;

      // ---- table-driven directed vectors ----
      for (int i = 0; i < 16; i++) begin
         reset = tbl[i].rst; vc_req = tbl[i].req; flit_sent = tbl[i].sent;
         flit_is_tail = tbl[i].tail; credit_return = tbl[i].ret;
         step();
         $display("row %0d: grant=%b busy=%b can=%b cc=%b err=%b", i,
                  vc_grant, vc_busy, port_can_send, credit_count, protocol_error);
         chk("tbl_grant", 32'(vc_grant), 32'(tbl[i].e_grant));
         chk("tbl_busy", 32'(vc_busy), 32'(tbl[i].e_busy));
         chk("tbl_can_send", 32'(port_can_send), 32'(tbl[i].e_can));
         chk("tbl_credits", 32'(credit_count), 32'(tbl[i].e_cc));
         chk("tbl_error", 32'(protocol_error), 32'(tbl[i].e_err));
         if (i == 2) begin
            chk("tbl_grant_id1", 32'(vc_grant_id[1*VW +: VW]), 32'd0);
            chk("tbl_owner0", 32'(vc_owner[0 +: PW]), 32'd1);
         end
      end

      // ---- hand sequence: round-robin with contention and VC reuse ----
      idle_inputs(); reset = 1'b0; step();
      reset = 1'b1; vc_req = 4'b0111; step();
      $display("rr seq: grant=%b busy=%b", vc_grant, vc_busy);
      chk("rr_first_grant", 32'(vc_grant), 32'b0001);
      chk("rr_first_id", 32'(vc_grant_id[0 +: VW]), 32'd0);
      vc_req = 4'b0110; step();
      $display("rr seq: grant=%b busy=%b", vc_grant, vc_busy);
      chk("rr_second_grant", 32'(vc_grant), 32'b0010);
      chk("rr_second_id", 32'(vc_grant_id[1*VW +: VW]), 32'd1);
      chk("rr_both_busy", 32'(vc_busy), 32'b11);
      vc_req = 4'b0100; step();
      chk("rr_port2_waits", 32'(vc_grant), 32'b0000);
      step();
      chk("rr_port2_still_waits", 32'(vc_grant), 32'b0000);
      flit_sent = 4'b0001; flit_is_tail = 4'b0001; step();
      $display("rr seq: tail from port0, busy=%b", vc_busy);
      chk("rr_vc0_released", 32'(vc_busy), 32'b10);
      chk("rr_no_grant_same_cycle", 32'(vc_grant), 32'b0000);
      flit_sent = '0; flit_is_tail = '0; step();
      $display("rr seq: grant=%b owner0=%0d", vc_grant, vc_owner[0 +: PW]);
      chk("rr_port2_grant", 32'(vc_grant), 32'b0100);
      chk("rr_port2_id", 32'(vc_grant_id[2*VW +: VW]), 32'd0);
      chk("rr_owner0_port2", 32'(vc_owner[0 +: PW]), 32'd2);

      // ---- hand sequence: reset mid-packet with a pending request ----
      vc_req = 4'b1000; reset = 1'b0; step();
      $display("mid-packet reset: busy=%b cc=%b", vc_busy, credit_count);
      chk("rst_busy_clear", 32'(vc_busy), 32'b00);
      chk("rst_credits", 32'(credit_count), 32'b1010);
      chk("rst_no_grant", 32'(vc_grant), 32'b0000);
      reset = 1'b1; step();
      $display("after reset: grant=%b busy=%b", vc_grant, vc_busy);
      chk("rst_pending_grant", 32'(vc_grant), 32'b1000);
      chk("rst_pending_id", 32'(vc_grant_id[3*VW +: VW]), 32'd0);
      chk("rst_pending_busy", 32'(vc_busy), 32'b01);
      idle_inputs(); step();

      // ---- randomized traffic against the reference model ----
      for (int c = 0; c < 800; c++) begin
         reset = (c % 60 != 0);
         vc_req = 4'($urandom);
         for (int p = 0; p < P; p++) begin
            if (m_can(p)) flit_sent[p] = ($urandom_range(0, 1) == 1);
            else          flit_sent[p] = ($urandom_range(0, 39) == 0);
            flit_is_tail[p] = ($urandom_range(0, 2) == 0);
         end
         for (int v = 0; v < V; v++) begin
            if (m_cred[v] < C) credit_return[v] = ($urandom_range(0, 1) == 1);
            else               credit_return[v] = ($urandom_range(0, 39) == 0);
         end
         step();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/spidergon_vc_allocator.md
Name: spidergon_vc_allocator

Overview:
Per-output-port virtual-channel allocator and credit tracker for one spidergon router node. Shares the NUM_OF_VIRTUAL_CHANNELS downstream VC buffers of one output port among the node's input ports (local, clockwise, anti-clockwise, across). Allocates a VC to a requesting head flit by round-robin, holds it until the tail flit passes, and gates flit forwarding on per-VC downstream credits.

Parameters:
NUM_OF_INPUT_PORTS, 4, number of requesting input ports (P)
NUM_OF_VIRTUAL_CHANNELS, 2, VCs on this output port (V)
VC_CREDITS, 2, flit slots per downstream VC buffer (NODE_BUFFER_WIDTH/FLIT_DATA_WIDTH)
PORT_ID_WIDTH, max(1,$clog2(P)), owner index width (PW)
VC_ID_WIDTH, max(1,$clog2(V)), VC index width (VW)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low (reset==0 at posedge resets)
vc_req  input  P  port p holds a head flit needing a VC; held high until granted
flit_sent  input  P  port p forwards one flit on its allocated VC this cycle
flit_is_tail  input  P  qualifies flit_sent[p]: flit is the tail (or HEADER single flit)
credit_return  input  V  downstream freed one slot of VC v
vc_grant  output  P  one-cycle grant pulse to port p
vc_grant_id  output  P*VW  VC index owned by port p; valid from grant until release
vc_busy  output  V  VC v allocated
vc_owner  output  V*PW  owning port of VC v (valid when vc_busy[v])
port_can_send  output  P  port p owns a VC with credit > 0
credit_count  output  V*($clog2(VC_CREDITS+1))  current credits per VC
protocol_error  output  1  sticky protocol violation flag

Behaviour:
- Reset (reset==0 at posedge): vc_busy=0, vc_owner=0, vc_grant=0, vc_grant_id=0, credits=VC_CREDITS per VC, rr pointer=0, protocol_error=0. Reset mid-packet drops all allocations; no in-flight state survives.
- Allocation, one grant max per cycle: eligible[p] = vc_req[p] & ~port_owns[p] & ~vc_grant[p]. Free VC = lowest index v with registered vc_busy[v]==0. If any eligible port and a free VC exist, pick the first eligible port at or after rr pointer (wrapping P-1 -> 0).
- Latency: decision in cycle N from registered state; in N+1 vc_grant[p]=1 (single pulse), vc_busy[v]=1, vc_owner[v]=p, vc_grant_id[p]=v, port_owns[p]=1. rr pointer <= (p+1) mod P. No grant: pointer unchanged.
- No free VC: requests wait, no grant; starvation-free via rotating pointer.
- Release: flit_sent[p]&flit_is_tail[p] with port_owns[p] -> vc_busy[v]=0 and port_owns[p]=0 in the next cycle. A VC released in cycle T is regranted at the earliest T+2 (decision in T+1). Credits are not reset on release.
- Credits per VC, range 0..VC_CREDITS: flit_sent from owner decrements; credit_return[v] increments; both in same cycle -> unchanged. Updates visible next cycle.
- port_can_send[p] = port_owns[p] & (credit of owned VC > 0); combinational from registers only.
- Errors, set protocol_error (sticky until reset), offending event otherwise ignored: flit_sent[p] while port_can_send[p]==0; credit_return[v] with credit==VC_CREDITS and no same-cycle decrement (saturates).
- Tail flit counts against credit like any flit; a tail sent with credit 0 is an error and does not release.

Test Plan:
- Hold reset=0 two cycles, all inputs 0 -> vc_busy=00, credit_count={2,2}, vc_grant=0000, protocol_error=0.
- vc_req=0010 at cycle 0 -> cycle 1 vc_grant=0010, vc_grant_id[1]=0, vc_busy=01, vc_owner[0]=1, port_can_send=0010; vc_grant=0 in cycle 2.
- vc_req=0111 from reset, pointer 0 -> port0 granted vc0 at cycle 1, port1 vc1 at cycle 2, port2 waits; port0 sends tail at cycle 5 -> vc_busy[0]=0 at 6, port2 granted vc0 at 7.
- Port1 on vc0 sends 2 body flits, no returns -> credit_count[0]=0, port_can_send[1]=0; credit_return=01 -> credit 1, can_send=1 next cycle; flit_sent+credit_return same cycle -> credit unchanged.
- flit_sent[3]=1 with port3 owning no VC -> protocol_error=1 next cycle, no credit change, stays 1; credit_return[1] with credit 2 -> credit stays 2, error set.
- Reset=0 while vc_busy=11 mid-packet -> next cycle vc_busy=00, credits {2,2}, pointer 0; a pending vc_req=1000 is granted vc0 at the first cycle after reset is released.
